// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard control for a 5-stage pipeline. It keeps EX/MEM shadow copies of
//   the destination fields and uses them to pick forwarding paths and detect
//   load-use stalls. Taken branches and jumps flush IF/ID. A memory-busy
//   freeze holds every pipeline register.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | normal issue, hazard logic active
//   WAIT  | memory asked for a freeze; stays here until mem_busy drops
//   RESUME| one cycle after the freeze ends, hazard logic active again
//
// Ports
//   clock, reset            : sole clock, synchronous active-high reset
//   id_rs/id_rt, id_use_*   : ID-stage source registers and their read flags
//   id_rn/id_wreg/id_m2reg  : ID-stage destination, register-write and load flags
//   id_taken                : ID-stage branch taken or jump
//   mem_busy                : data memory requests a pipeline freeze
//   wpcir                   : PC and IF/ID write enable
//   bubble                  : force ID/EX control to NOP
//   flush_ifid              : replace the IF/ID instruction with NOP
//   freeze                  : hold all pipeline registers
//   fwda/fwdb               : operand source (00 rf, 01 EX alu, 10 MEM alu, 11 MEM load)
//   stall_cnt               : saturating count of freeze/bubble cycles
//   state                   : 00 RUN, 01 WAIT, 10 RESUME
module pipe_hazard_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  id_rn,
  input  logic        id_wreg,
  input  logic        id_m2reg,
  input  logic        id_taken,
  input  logic        mem_busy,
  output logic        wpcir,
  output logic        bubble,
  output logic        flush_ifid,
  output logic        freeze,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic [15:0] stall_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_WAIT   = 2'b01,
    ST_RESUME = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  e_rn_q, e_rn_d, m_rn_q, m_rn_d;
  logic        e_wreg_q, e_wreg_d, m_wreg_q, m_wreg_d;
  logic        e_m2reg_q, e_m2reg_d, m_m2reg_q, m_m2reg_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        load_use;

  // A load in EX cannot forward yet, so it only ever matches through MEM.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic [4:0] e_rn, input logic e_wreg,
                                          input logic e_m2reg,
                                          input logic [4:0] m_rn, input logic m_wreg,
                                          input logic m_m2reg);
    logic [1:0] sel;
    sel = 2'b00;
    if (e_wreg && (e_rn != 5'd0) && (e_rn == src) && !e_m2reg)
      sel = 2'b01;
    else if (m_wreg && (m_rn != 5'd0) && (m_rn == src))
      sel = m_m2reg ? 2'b11 : 2'b10;
    return sel;
  endfunction

  always_comb begin
    load_use = e_wreg_q && e_m2reg_q && (e_rn_q != 5'd0) &&
               ((id_use_rs && (e_rn_q == id_rs)) || (id_use_rt && (e_rn_q == id_rt)));

    fwda       = fwd_sel(id_rs, e_rn_q, e_wreg_q, e_m2reg_q, m_rn_q, m_wreg_q, m_m2reg_q);
    fwdb       = fwd_sel(id_rt, e_rn_q, e_wreg_q, e_m2reg_q, m_rn_q, m_wreg_q, m_m2reg_q);
    wpcir      = 1'b1;
    bubble     = 1'b0;
    flush_ifid = 1'b0;
    freeze     = 1'b0;

    if (reset) begin
      wpcir  = 1'b0;
      bubble = 1'b1;
      fwda   = 2'b00;
      fwdb   = 2'b00;
    end else if (mem_busy) begin
      freeze = 1'b1;
      wpcir  = 1'b0;
    end else if (load_use) begin
      // Branch decision waits until the stalled instruction is re-presented.
      wpcir  = 1'b0;
      bubble = 1'b1;
    end else if (id_taken) begin
      flush_ifid = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: if (!mem_busy) state_d = ST_RESUME;
      default: state_d = ST_RUN;
    endcase
    if (mem_busy) state_d = ST_WAIT;

    e_rn_d    = e_rn_q;
    e_wreg_d  = e_wreg_q;
    e_m2reg_d = e_m2reg_q;
    m_rn_d    = m_rn_q;
    m_wreg_d  = m_wreg_q;
    m_m2reg_d = m_m2reg_q;
    if (!freeze) begin
      m_rn_d    = e_rn_q;
      m_wreg_d  = e_wreg_q;
      m_m2reg_d = e_m2reg_q;
      e_rn_d    = bubble ? 5'd0 : id_rn;
      e_wreg_d  = bubble ? 1'b0 : id_wreg;
      e_m2reg_d = bubble ? 1'b0 : id_m2reg;
    end

    stall_cnt_d = stall_cnt_q;
    if ((freeze || bubble) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      e_rn_q      <= 5'd0;
      e_wreg_q    <= 1'b0;
      e_m2reg_q   <= 1'b0;
      m_rn_q      <= 5'd0;
      m_wreg_q    <= 1'b0;
      m_m2reg_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      e_rn_q      <= e_rn_d;
      e_wreg_q    <= e_wreg_d;
      e_m2reg_q   <= e_m2reg_d;
      m_rn_q      <= m_rn_d;
      m_wreg_q    <= m_wreg_d;
      m_m2reg_q   <= m_m2reg_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule
